// File: rtl/div_ratio_ctrl.sv
// ============================================================================
// Module   : div_ratio_ctrl
// Purpose  : Round-robin arbiter that loads a new divide ratio into a clock
//            divider and waits for it to settle. Optional settle timeout is
//            enabled by defining DIV_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ratio_ctrl #(
  parameter int               WIDTH       = 8,
  parameter int               NREQ        = 4,
  parameter int               SETTLE_TC   = 2,
  parameter int               TIMEOUT     = 1024,
  parameter logic [WIDTH-1:0] RESET_RATIO = WIDTH'(8'h0f)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] ratio_in,
  input  logic                  div_tc,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic                  err,
  output logic                  div_load,
  output logic [WIDTH-1:0]      div_ratio,
  output logic                  busy
);

  localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_tc_w  = $clog2(SETTLE_TC + 1);

  if (SETTLE_TC < 1) begin : g_bad_settle_tc
    $error("SETTLE_TC must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_ptr_w-1:0]   r_ptr;
  logic [c_ptr_w-1:0]   w_win;
  logic [NREQ-1:0]      r_gnt;
  logic [NREQ-1:0]      w_win_oh;
  logic [WIDTH-1:0]     r_ratio;
  logic [WIDTH-1:0]     r_div_ratio;
  logic [WIDTH-1:0]     w_win_ratio;
  logic [WIDTH-1:0]     w_ratio_arr [NREQ];
  logic [c_tc_w-1:0]    r_tc_cnt;
  logic                 w_legal;
  logic                 w_tc_last;
  logic                 w_to_last;

  // Scan from the farthest candidate back to r_ptr so the nearest requester wins.
  always_comb begin : p_winner
    int                 t;
    logic [c_ptr_w-1:0] v_idx;
    t           = 0;
    v_idx       = '0;
    w_win       = '0;
    w_win_oh    = '0;
    w_win_ratio = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ratio_arr[i] = ratio_in[i*WIDTH +: WIDTH];
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      t = int'(r_ptr) + k;
      if (t >= NREQ) t = t - NREQ;
      v_idx = c_ptr_w'(t);
      if (req[v_idx]) begin
        w_win           = v_idx;
        w_win_oh        = '0;
        w_win_oh[v_idx] = 1'b1;
        w_win_ratio     = w_ratio_arr[v_idx];
      end
    end
  end

  assign w_legal   = |r_ratio[WIDTH-1:1];
  assign w_tc_last = (r_tc_cnt == c_tc_w'(SETTLE_TC - 1));

`ifdef DIV_CTRL_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT + 1);
  logic [c_to_w-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_to_cnt <= '0;
    end else if (r_state == S_SETTLE) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_to_last = (r_to_cnt == c_to_w'(TIMEOUT - 1));
`else
  assign w_to_last = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    done     = 1'b0;
    err      = 1'b0;
    div_load = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (|req) w_next = S_LOAD;
      S_LOAD: begin
        div_load = w_legal;
        w_next   = w_legal ? S_SETTLE : S_ERR;
      end
      S_SETTLE: begin
        // A completing pulse takes precedence over a simultaneous timeout.
        if (div_tc && w_tc_last) w_next = S_DONE;
        else if (w_to_last)      w_next = S_ERR;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        done   = 1'b1;
        err    = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_ratio     <= '0;
      r_div_ratio <= RESET_RATIO;
      r_tc_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt   <= w_win_oh;
            r_ratio <= w_win_ratio;
            r_ptr   <= (w_win == c_ptr_w'(NREQ - 1)) ? '0 : w_win + 1'b1;
          end
        end
        S_LOAD: begin
          r_tc_cnt <= '0;
          if (w_legal) r_div_ratio <= r_ratio;
        end
        S_SETTLE: if (div_tc) r_tc_cnt <= r_tc_cnt + 1'b1;
        S_DONE, S_ERR: r_gnt <= '0;
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign div_ratio = div_load ? r_ratio : r_div_ratio;

endmodule

`default_nettype wire

// File: tb/tb_div_ratio_ctrl.sv
// ============================================================================
// Module   : tb_div_ratio_ctrl
// Purpose  : Directed scoreboard bench for div_ratio_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_ratio_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] ratio_in;
  logic        div_tc;
  logic [3:0]  gnt;
  logic        done;
  logic        err;
  logic        div_load;
  logic [7:0]  div_ratio;
  logic        busy;

  div_ratio_ctrl #(
    .WIDTH(8), .NREQ(4), .SETTLE_TC(2), .TIMEOUT(16), .RESET_RATIO(8'h0f)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ratio_in(ratio_in), .div_tc(div_tc),
    .gnt(gnt), .done(done), .err(err), .div_load(div_load),
    .div_ratio(div_ratio), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] ratio;
    bit         err;
    bit         load;
  } exp_t;

  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model_ratio = 8'h0f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] r, input bit e, input bit l);
    exp_t x;
    x.gnt = g; x.ratio = r; x.err = e; x.load = l;
    q.push_back(x);
  endtask

  // One full grant sequence; div_tc pulses every `period` cycles once `hold`
  // cycles have passed since div_load. Returns load-to-done cycle count.
  task automatic run_txn(input int period, input int hold, input bit drop,
                         input int max_cyc, output int lat);
    int         k = 0;
    int         nload = 0;
    int         load_at = -1;
    int         done_at = -1;
    logic [7:0] load_ratio = 8'h00;
    logic [3:0] g_s = 4'h0;
    logic       e_s = 1'b0;
    logic [7:0] dr_s = 8'h00;
    exp_t       e;
    lat = -1;
    while (k < max_cyc && done_at < 0) begin
      @(negedge clk);
      k++;
      if (div_load === 1'b1) begin
        nload++;
        load_at    = k;
        load_ratio = div_ratio;
      end
      if (done === 1'b1) begin
        done_at = k;
        g_s     = gnt;
        e_s     = err;
        dr_s    = div_ratio;
      end else begin
        if (drop && gnt != 4'h0) begin
          req      = 4'h0;
          ratio_in = ~ratio_in;
        end
        div_tc = (period > 0 && load_at >= 0 && (k - load_at) >= hold &&
                  (k % period) == period - 1);
      end
    end
    div_tc = 1'b0;
    check("done_seen", 32'(done_at >= 0), 32'd1);
    if (done_at >= 0) begin
      check("sb_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.load) model_ratio = e.ratio;
        check("gnt_at_done", 32'(g_s), 32'(e.gnt));
        check("err_at_done", 32'(e_s), 32'(e.err));
        check("load_count", nload, e.load ? 1 : 0);
        check("ratio_at_done", 32'(dr_s), 32'(model_ratio));
        if (e.load) check("ratio_at_load", 32'(load_ratio), 32'(e.ratio));
      end
      if (load_at >= 0) lat = done_at - load_at;
    end
    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    clk      = 1'b0;
    rst      = 1'b1;
    req      = 4'h0;
    ratio_in = 32'h0;
    div_tc   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("idle_ratio", 32'(div_ratio), 32'h0f);
      check("idle_busy0", 32'(busy), 32'd0);
      check("idle_gnt0", 32'(gnt), 32'd0);
    end

    // Single requester, req and ratio_in changed after the grant.
    req = 4'b0010;
    ratio_in = {8'd0, 8'd0, 8'd6, 8'd0};
    push(4'b0010, 8'd6, 1'b0, 1'b1);
    run_txn(6, 0, 1'b1, 100, lat);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ratio = 8'h0f;
    check("ratio_after_rst", 32'(div_ratio), 32'h0f);

    // All requesting: round-robin from index 0, tc every cycle for min latency.
    req = 4'b1111;
    ratio_in = {8'd13, 8'd12, 8'd11, 8'd10};
    push(4'b0001, 8'd10, 1'b0, 1'b1);
    push(4'b0010, 8'd11, 1'b0, 1'b1);
    push(4'b0100, 8'd12, 1'b0, 1'b1);
    push(4'b1000, 8'd13, 1'b0, 1'b1);
    push(4'b0001, 8'd10, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run_txn(1, 0, 1'b0, 100, lat);
      check("min_latency", lat, 3);
    end

    // Illegal ratios 1 and 0.
    req = 4'b0001;
    ratio_in = {8'd13, 8'd12, 8'd11, 8'd1};
    push(4'b0001, 8'd1, 1'b1, 1'b0);
    run_txn(1, 0, 1'b0, 100, lat);
    req = 4'b0100;
    ratio_in = {8'd13, 8'd0, 8'd11, 8'd1};
    push(4'b0100, 8'd0, 1'b1, 1'b0);
    run_txn(1, 0, 1'b0, 100, lat);

    // Requester 0 holding: others served before it is re-granted.
    req = 4'b0011;
    ratio_in = {8'd13, 8'd12, 8'd21, 8'd20};
    push(4'b0001, 8'd20, 1'b0, 1'b1);
    push(4'b0010, 8'd21, 1'b0, 1'b1);
    push(4'b0001, 8'd20, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) run_txn(1, 0, 1'b0, 100, lat);

    req = 4'b0100;
    ratio_in = {8'd13, 8'd9, 8'd21, 8'd20};
`ifdef DIV_CTRL_TIMEOUT_EN
    push(4'b0100, 8'd9, 1'b1, 1'b1);
    run_txn(0, 1000, 1'b0, 100, lat);
    check("timeout_latency", lat, 17);
`else
    push(4'b0100, 8'd9, 1'b0, 1'b1);
    run_txn(1, 40, 1'b0, 100, lat);
    check("settle_waits", 32'(lat > 40), 32'd1);
`endif

    // Reset while in SETTLE.
    req = 4'b0001;
    ratio_in = {8'd13, 8'd9, 8'd21, 8'd20};
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (div_load === 1'b1) seen = 1;
    end
    check("rst_test_load", seen, 1);
    @(negedge clk);
    check("in_settle_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'h0;
    check("rst_settle_gnt", 32'(gnt), 32'd0);
    check("rst_settle_busy", 32'(busy), 32'd0);
    check("rst_settle_ratio", 32'(div_ratio), 32'h0f);
    model_ratio = 8'h0f;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check("rst_no_done", seen, 0);

    // Pointer restarts at 0 after reset.
    req = 4'b1111;
    ratio_in = {8'd13, 8'd12, 8'd11, 8'd10};
    push(4'b0001, 8'd10, 1'b0, 1'b1);
    run_txn(1, 0, 1'b1, 100, lat);
    check("sb_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
